// File: rtl/codes_pkg.sv
// Shared CPU codes: data width, memory opcodes, load/store FSM states and
// lane helpers reused by the control FSM and the load/store unit.
package codes;

  typedef logic [31:0] size_t;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } access_size_t;

  function automatic logic is_load(opcode_t op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(opcode_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // SZ_NONE marks an opcode that is not a memory operation.
  function automatic access_size_t access_size(opcode_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      OP_LW, OP_SW:         return SZ_WORD;
      default:              return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_aligned(access_size_t sz, logic [1:0] offset);
    case (sz)
      SZ_HALF: return ~offset[0];
      SZ_WORD: return offset == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(access_size_t sz, logic [1:0] offset);
    case (sz)
      SZ_BYTE: return 4'b0001 << offset;
      SZ_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic size_t lane_data(access_size_t sz, size_t data);
    case (sz)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends
// it to 32 bits; words pass straight through.
module load_extract
  import codes::*;
(
  input  size_t      readdata,
  input  logic [1:0] offset,
  input  opcode_t    opcode,
  output size_t      result
);

  logic [7:0]  lanes [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = readdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = lanes[offset];
  assign sel_half = offset[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};

  always_comb begin
    result = readdata;
    case (opcode)
      OP_LB:   result = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  result = {24'h0, sel_byte};
      OP_LH:   result = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  result = {16'h0, sel_half};
      default: result = readdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store unit: one single-beat Avalon-style transfer per request, with
// lane selection, wait-state handling and misalignment rejection.
module mem_access
  import codes::*;
(
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  opcode_t    opcode_i,
  input  size_t      effective_address_i,
  input  size_t      store_data_i,
  output size_t      address_o,
  output logic       read_o,
  output logic       write_o,
  output logic [3:0] byteenable_o,
  output size_t      writedata_o,
  input  size_t      readdata_i,
  input  logic       waitrequest_i,
  output size_t      load_data_o,
  output logic       done_o,
  output logic       busy_o,
  output logic       misaligned_o
);

  mem_state_t   state_reg;
  opcode_t      op_reg;
  logic [1:0]   offset_reg;
  size_t        address_reg;
  logic [3:0]   be_reg;
  size_t        wd_reg;
  logic         read_reg;
  logic         write_reg;
  size_t        load_data_reg;
  logic         done_reg;
  logic         busy_reg;
  logic         mis_reg;

  access_size_t req_size;
  logic [1:0]   req_offset;
  size_t        load_result;

  assign req_size   = access_size(opcode_i);
  assign req_offset = effective_address_i[1:0];

  // Fed only by registered opcode/offset; readdata_i reaches nothing but the
  // load_data register.
  load_extract u_load_extract (
    .readdata (readdata_i),
    .offset   (offset_reg),
    .opcode   (op_reg),
    .result   (load_result)
  );

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg     <= IDLE;
      op_reg        <= OP_LB;
      offset_reg    <= 2'b00;
      address_reg   <= '0;
      be_reg        <= 4'b0000;
      wd_reg        <= '0;
      read_reg      <= 1'b0;
      write_reg     <= 1'b0;
      load_data_reg <= '0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      mis_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      mis_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            busy_reg <= 1'b1;
            if (req_size == SZ_NONE) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else if (!is_aligned(req_size, req_offset)) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              mis_reg   <= 1'b1;
            end else begin
              state_reg   <= ACCESS;
              op_reg      <= opcode_i;
              offset_reg  <= req_offset;
              address_reg <= {effective_address_i[31:2], 2'b00};
              be_reg      <= lane_enable(req_size, req_offset);
              wd_reg      <= lane_data(req_size, store_data_i);
              read_reg    <= is_load(opcode_i);
              write_reg   <= is_store(opcode_i);
            end
          end
        end
        ACCESS: begin
          if (!waitrequest_i) begin
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
            state_reg <= DONE;
            done_reg  <= 1'b1;
            if (is_load(op_reg))
              load_data_reg <= load_result;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          read_reg  <= 1'b0;
          write_reg <= 1'b0;
        end
      endcase
    end
  end

  assign address_o    = address_reg;
  assign read_o       = read_reg;
  assign write_o      = write_reg;
  assign byteenable_o = be_reg;
  assign writedata_o  = wd_reg;
  assign load_data_o  = load_data_reg;
  assign done_o       = done_reg;
  assign busy_o       = busy_reg;
  assign misaligned_o = mis_reg;

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access: a driver plays CPU and slave,
// monitors compare bus cycles and completions against a reference model.
module tb_mem_access;
  import codes::*;

  logic       clk;
  logic       reset_n_i;
  logic       start_i;
  opcode_t    opcode_i;
  size_t      effective_address_i;
  size_t      store_data_i;
  size_t      address_o;
  logic       read_o;
  logic       write_o;
  logic [3:0] byteenable_o;
  size_t      writedata_o;
  size_t      readdata_i;
  logic       waitrequest_i;
  size_t      load_data_o;
  logic       done_o;
  logic       busy_o;
  logic       misaligned_o;

  mem_access dut (
    .clk                 (clk),
    .reset_n_i           (reset_n_i),
    .start_i             (start_i),
    .opcode_i            (opcode_i),
    .effective_address_i (effective_address_i),
    .store_data_i        (store_data_i),
    .address_o           (address_o),
    .read_o              (read_o),
    .write_o             (write_o),
    .byteenable_o        (byteenable_o),
    .writedata_o         (writedata_o),
    .readdata_i          (readdata_i),
    .waitrequest_i       (waitrequest_i),
    .load_data_o         (load_data_o),
    .done_o              (done_o),
    .busy_o              (busy_o),
    .misaligned_o        (misaligned_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_exp_t;

  typedef struct {
    logic        mis;
    logic [31:0] ld;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_load = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: access width in bytes, 0 for non-memory opcodes.
  function automatic int op_bytes(opcode_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic logic op_reads(opcode_t op);
    return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
  endfunction

  // Issues one request, plays the slave, pushes expectations, checks latency.
  task automatic do_req(input opcode_t op, input logic [31:0] ea, input logic [31:0] sd,
                        input logic [31:0] rd, input int nwait, input logic junk);
    int sz, off, cycles, rem, exp_lat;
    logic mis, access;
    logic [63:0] m64;
    logic [31:0] mask, wd, v;
    logic [3:0] be;
    sz     = op_bytes(op);
    off    = int'(ea % 4);
    mis    = (sz != 0) && ((ea % sz) != 0);
    access = (sz != 0) && !mis;
    if (access) begin
      m64  = (64'd1 << (8 * sz)) - 64'd1;
      mask = m64[31:0];
      be   = 4'(((1 << sz) - 1) << off);
      wd   = 32'h0;
      for (int i = 0; i < 4 / sz; i++) wd = wd | ((sd & mask) << (8 * sz * i));
      bus_q.push_back('{op_reads(op), ea & ~32'h3, be, wd});
      if (op_reads(op)) begin
        v = (rd >> (8 * off)) & mask;
        if ((op == OP_LB || op == OP_LH) && v[8*sz-1]) v = v | ~mask;
        model_load = v;
      end
    end
    done_q.push_back('{mis, model_load});
    exp_lat = access ? 2 + nwait : 1;

    start_i = 1'b1; opcode_i = op; effective_address_i = ea; store_data_i = sd;
    rem = nwait;
    waitrequest_i = (rem > 0);
    readdata_i = (rem > 0) ? $urandom : rd;
    @(posedge clk); #1;
    start_i = 1'b0;
    cycles = 1;
    while (!done_o && cycles < 64) begin
      start_i = junk && (cycles == 2);
      opcode_i = OP_SW; effective_address_i = $urandom & ~32'h3;
      @(posedge clk); #1;
      if (rem > 0) rem--;
      waitrequest_i = (rem > 0);
      readdata_i = (rem > 0) ? $urandom : rd;
      cycles++;
    end
    start_i = 1'b0;
    check($sformatf("latency op=%0d ea=%h", op, ea), cycles, exp_lat);
    $display("txn op=%0d ea=%h sd=%h rd=%h waits=%0d latency=%0d load=%h mis=%0b",
             op, ea, sd, rd, nwait, cycles, load_data_o, misaligned_o);
    @(posedge clk); #1;
    check("busy_after_done", busy_o, 1'b0);
  endtask

  // Bus monitor: pops one expectation per strobe burst and checks stability.
  initial begin
    bus_exp_t cur;
    logic prev, have;
    prev = 1'b0; have = 1'b0;
    cur = '{1'b0, 32'h0, 4'h0, 32'h0};
    forever begin
      @(negedge clk);
      if (read_o || write_o) begin
        if (!prev) begin
          if (bus_q.size() == 0) begin
            check("bus_unexpected_strobe", 1'b1, 1'b0);
            have = 1'b0;
          end else begin
            cur = bus_q.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          check("bus_read", read_o, cur.rd);
          check("bus_write", write_o, !cur.rd);
          check("bus_address", address_o, cur.addr);
          check("bus_byteenable", byteenable_o, cur.be);
          if (!cur.rd) check("bus_writedata", writedata_o, cur.wd);
        end
      end
      prev = read_o || write_o;
    end
  end

  // Completion monitor.
  initial begin
    done_exp_t e;
    forever begin
      @(negedge clk);
      if (done_o) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 1'b1, 1'b0);
        end else begin
          e = done_q.pop_front();
          check("misaligned", misaligned_o, e.mis);
          check("load_data", load_data_o, e.ld);
          check("busy_with_done", busy_o, 1'b1);
        end
      end else if (misaligned_o) begin
        check("misaligned_without_done", 1'b1, 1'b0);
      end
    end
  end

  initial begin
    logic [3:0] r4;
    int done_seen;
    reset_n_i = 1'b0; start_i = 1'b0; opcode_i = OP_LB;
    effective_address_i = 32'h0; store_data_i = 32'h0;
    readdata_i = 32'h0; waitrequest_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n_i = 1'b1;
    check("rst_read", read_o, 1'b0);
    check("rst_write", write_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_mis", misaligned_o, 1'b0);
    check("rst_addr", address_o, 32'h0);
    check("rst_be", byteenable_o, 4'h0);
    check("rst_wd", writedata_o, 32'h0);
    check("rst_load", load_data_o, 32'h0);
    @(posedge clk); #1;

    do_req(OP_LW,  32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 0, 1'b0);
    do_req(OP_LB,  32'h0000_1003, 32'h0,         32'h8011_2233, 0, 1'b0);
    do_req(OP_LBU, 32'h0000_1003, 32'h0,         32'h8011_2233, 0, 1'b0);
    do_req(OP_SH,  32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0, 1'b0);
    do_req(OP_LHU, 32'h0000_1002, 32'h0,         32'h9876_0000, 3, 1'b1);
    do_req(OP_LW,  32'h0000_1001, 32'h0,         32'h1111_1111, 0, 1'b0);
    do_req(OP_SH,  32'h0000_2001, 32'hFFFF_FFFF, 32'h0,         0, 1'b0);
    r4 = 4'd12;
    do_req(opcode_t'(r4), 32'h0000_3000, 32'h0,  32'h2222_2222, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      r4 = 4'($urandom_range(0, 9));
      do_req(opcode_t'(r4), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset mid-ACCESS: strobe drops immediately and no completion follows.
    bus_q.push_back('{1'b1, 32'h0000_4000, 4'hF, 32'h0});
    start_i = 1'b1; opcode_i = OP_LW; effective_address_i = 32'h0000_4000;
    waitrequest_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    @(posedge clk); #1;
    check("abort_read_before", read_o, 1'b1);
    #2 reset_n_i = 1'b0;
    #1;
    check("abort_read", read_o, 1'b0);
    check("abort_busy", busy_o, 1'b0);
    check("abort_addr", address_o, 32'h0);
    check("abort_be", byteenable_o, 4'h0);
    check("abort_load", load_data_o, 32'h0);
    model_load = 32'h0;
    @(posedge clk); #1;
    reset_n_i = 1'b1; waitrequest_i = 1'b0;
    done_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done_o) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    $display("txn reset-abort LW ea=00004000 done_pulses=%0d", done_seen);

    do_req(OP_LH, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 1, 1'b0);
    check("bus_queue_drained", bus_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Load/store unit that sits directly downstream of the ALU. It takes the ALU's effective address and store value and runs a single-beat transfer on the Avalon-style data bus. Each transfer has byte-lane selection, stall handling and misalignment detection. For loads it returns a lane-extracted, sign- or zero-extended 32-bit result for register writeback. The CPU control FSM issues one request at a time and stalls until `done_o`.

## Interface
Parameters: none. Widths come from `size_t` (32 bit) in `codes`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request strobe, one cycle; sampled only in IDLE.
- `opcode_i`  in  `opcode_t`  one of OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW.
- `effective_address_i`  in  32  byte address from the ALU.
- `store_data_i`  in  32  rt value; the low byte or half is the data to store.
- `address_o`  out  32  word-aligned bus address, `{ea[31:2], 2'b00}`.
- `read_o` / `write_o`  out  1  bus strobes.
- `byteenable_o`  out  4  active lanes.
- `writedata_o`  out  32  lane-shifted store data.
- `readdata_i`  in  32  bus read data; valid when `read_o && !waitrequest_i`.
- `waitrequest_i`  in  1  slave stall.
- `load_data_o`  out  32  extended load result; held until the next load completes.
- `done_o`  out  1  one-cycle completion pulse.
- `busy_o`  out  1  high in any state other than IDLE.
- `misaligned_o`  out  1  high with `done_o` when the request was rejected.

## Operation
Lane convention: little-endian lanes. Byte offset k = ea[1:0] maps to bits [8k+7:8k].
- Byte access: byteenable `4'b0001 << k`; `writedata_o = {4{store_data_i[7:0]}}`.
- Half access: requires ea[0] = 0. Byteenable is `4'b0011` (k=0) or `4'b1100` (k=2); `writedata_o = {2{store_data_i[15:0]}}`.
- Word access: requires ea[1:0] = 0; byteenable `4'b1111`; `writedata_o = store_data_i`.
- Load extraction: select the byte or half at offset k. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.

FSM with states IDLE, ACCESS, DONE:
- IDLE, `start_i` = 1, legal and aligned request: register opcode, address, byteenable and writedata, then go to ACCESS.
- IDLE, `start_i` = 1, misaligned request: no bus cycle. Go to DONE with the misaligned flag set; `load_data_o` is unchanged.
- IDLE, `start_i` = 1, opcode not in the list: go to DONE. No bus cycle, no misaligned flag, `load_data_o` unchanged.
- ACCESS: hold `read_o` or `write_o`, `address_o`, `byteenable_o` and `writedata_o` stable while `waitrequest_i` = 1. On the edge where `waitrequest_i` = 0, end the transfer, capture the extracted load data for loads, and go to DONE.
- DONE: `done_o` = 1, plus `misaligned_o` if flagged. Always return to IDLE next cycle.
- `start_i` outside IDLE is ignored; there is no queueing.
- Store requests never modify `load_data_o`.

## Timing
- Reset values: state IDLE; `read_o`, `write_o`, `done_o`, `busy_o` and `misaligned_o` are 0. `byteenable_o`, `address_o`, `writedata_o` and `load_data_o` are 0.
- Reset asserted mid-ACCESS drops the strobes asynchronously. No `done_o` is produced for the aborted request.
- Request sampled at edge 0: strobes are visible in cycle 1.
- Zero-wait slave: transfer completes at edge 1, `done_o` is high in cycle 2, `busy_o` is high in cycles 1–2. Load latency is 2 cycles, plus 1 per wait cycle.
- Rejected or non-memory request: `done_o` in cycle 1, and no strobe is ever asserted.
- All outputs are driven from registers; there is no combinational path from `readdata_i` or `waitrequest_i` to any output.
- `load_data_o` changes on the same edge that raises `done_o`.

## Structure
- Add `mem_state_t` (IDLE/ACCESS/DONE) to the shared `codes` package, next to `opcode_t`.
- Add package functions `is_load(opcode_t)` and `is_store(opcode_t)` to `codes` for reuse by the control FSM.
- Sub-module `load_extract` (combinational): inputs `readdata`, `offset[1:0]`, opcode; output is the extended 32-bit value. It is instantiated once, fed by the registered opcode and offset.

## Test plan
- LW, ea `0x1000`, `readdata_i` `0xDEADBEEF`, no wait: strobes in cycle 1 with `address_o` `0x1000` and byteenable `1111`. `done_o` in cycle 2, `load_data_o` `0xDEADBEEF`.
- LB at ea `0x1003` with `readdata_i` `0x80112233` gives byteenable `1000` and `load_data_o` `0xFFFFFF80`. LBU with the same inputs gives `0x00000080`.
- SH at ea `0x2002` with `store_data_i` `0x1234ABCD`: `writedata_o` `0xABCDABCD`, byteenable `1100`, `write_o` for one cycle.
- LHU at ea `0x1002` with `waitrequest_i` high for 3 cycles: outputs stay stable for those 3 cycles. `done_o` lands in cycle 5, and `start_i` pulsed during cycle 2 is ignored.
- Misaligned requests (LW at ea `0x1001`, SH at ea `0x2001`): `done_o` and `misaligned_o` in cycle 1, no `read_o` or `write_o` ever, `load_data_o` unchanged.
- `reset_n_i` pulled low mid-ACCESS: `read_o` drops before the next edge, all outputs return to reset values, and no `done_o` follows.
